// File: rtl/uop_pkg.sv
// Shared micro-op types, opcode encodings and instruction-queue defaults for the decode stage.
package uop_pkg;

    localparam int unsigned INSTR_Q_DEPTH = 8;
    localparam int unsigned INSTR_Q_WIDTH = 2;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [3:0] {
        UOP_ILLEGAL = 4'd0,
        UOP_ADD     = 4'd1,
        UOP_SUB     = 4'd2,
        UOP_ADDI    = 4'd3,
        UOP_LW      = 4'd4,
        UOP_SW      = 4'd5,
        UOP_BEQ     = 4'd6,
        UOP_LUI     = 4'd7
    } uop_op_e;

    typedef struct packed {
        uop_op_e     op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } uop_insn;

    function automatic logic [31:0] sext12(input logic [11:0] x);
        return {{20{x[11]}}, x};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-beat and IQ-push bundle of the decode stage; the stage is the slave side.
interface decode_stage_if
    import uop_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH = 32,
    parameter int unsigned FETCH_WIDTH       = 2,
    parameter int unsigned PUSH_WIDTH        = INSTR_Q_WIDTH,
    parameter int unsigned IQ_DEPTH          = INSTR_Q_DEPTH
);
    localparam int unsigned FREE_W = $clog2(IQ_DEPTH + 1);
    localparam int unsigned PCNT_W = $clog2(PUSH_WIDTH + 1);

    logic                                          fetch_valid_in;
    logic [FETCH_WIDTH-1:0]                        fetch_lane_mask_in;
    logic [FETCH_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] fetch_ops_in;
    logic                                          fetch_ready_out;
    logic [FREE_W-1:0]                             iq_free_slots_in;
    logic [PCNT_W-1:0]                             iq_push_count_out;
    uop_insn [PUSH_WIDTH-1:0]                      iq_uops_out;

    modport master (
        output fetch_valid_in, fetch_lane_mask_in, fetch_ops_in, iq_free_slots_in,
        input  fetch_ready_out, iq_push_count_out, iq_uops_out
    );

    modport slave (
        input  fetch_valid_in, fetch_lane_mask_in, fetch_ops_in, iq_free_slots_in,
        output fetch_ready_out, iq_push_count_out, iq_uops_out
    );
endinterface

// File: rtl/decode_lane.sv
// Combinational decoder for one 32-bit encoding; anything unrecognised becomes UOP_ILLEGAL.
module decode_lane
    import uop_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH = 32
) (
    input  logic [INSTRUCTION_WIDTH-1:0] insn_i,
    output uop_insn                      uop_o_c
);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = insn_i[6:0];
    assign f3  = insn_i[14:12];
    assign f7  = insn_i[31:25];

    always_comb begin
        uop_o_c = '0;
        case (opc)
            OPC_OP: begin
                if (f3 == F3_ADD && (f7 == F7_BASE || f7 == F7_ALT)) begin
                    uop_o_c.op  = (f7 == F7_ALT) ? UOP_SUB : UOP_ADD;
                    uop_o_c.rd  = insn_i[11:7];
                    uop_o_c.rs1 = insn_i[19:15];
                    uop_o_c.rs2 = insn_i[24:20];
                end
            end
            OPC_OP_IMM, OPC_LOAD: begin
                if ((opc == OPC_OP_IMM && f3 == F3_ADD) || (opc == OPC_LOAD && f3 == F3_WORD)) begin
                    uop_o_c.op  = (opc == OPC_LOAD) ? UOP_LW : UOP_ADDI;
                    uop_o_c.rd  = insn_i[11:7];
                    uop_o_c.rs1 = insn_i[19:15];
                    uop_o_c.imm = sext12(insn_i[31:20]);
                end
            end
            OPC_STORE: begin
                if (f3 == F3_WORD) begin
                    uop_o_c.op  = UOP_SW;
                    uop_o_c.rs1 = insn_i[19:15];
                    uop_o_c.rs2 = insn_i[24:20];
                    uop_o_c.imm = sext12({insn_i[31:25], insn_i[11:7]});
                end
            end
            OPC_BRANCH: begin
                if (f3 == F3_BEQ) begin
                    uop_o_c.op  = UOP_BEQ;
                    uop_o_c.rs1 = insn_i[19:15];
                    uop_o_c.rs2 = insn_i[24:20];
                    uop_o_c.imm = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25],
                                   insn_i[11:8], 1'b0};
                end
            end
            OPC_LUI: begin
                uop_o_c.op  = UOP_LUI;
                uop_o_c.rd  = insn_i[11:7];
                uop_o_c.imm = {insn_i[31:12], 12'h000};
            end
            default: uop_o_c = '0;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// Superscalar decode stage: per-lane decode, lane compaction into a circular hold buffer, IQ push.
// Optional perf counters are built when DECODE_PERF_EN is defined.
module decode_stage
    import uop_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH = 32,
    parameter int unsigned FETCH_WIDTH       = 2,
    parameter int unsigned PUSH_WIDTH        = INSTR_Q_WIDTH,
    parameter int unsigned HOLD_DEPTH        = 4,
    parameter int unsigned IQ_DEPTH          = INSTR_Q_DEPTH
) (
    input  logic          clk_in,
    input  logic          rst_N_in,
    input  logic          flush_in,
    decode_stage_if.slave io
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]   perf_decoded_out,
    output logic [31:0]   perf_stall_out
`endif
);
    localparam int unsigned PTR_W  = $clog2(HOLD_DEPTH);
    localparam int unsigned CNT_W  = $clog2(HOLD_DEPTH + 1);
    localparam int unsigned PCNT_W = $clog2(PUSH_WIDTH + 1);
    localparam int unsigned FREE_W = $clog2(IQ_DEPTH + 1);

    uop_insn           dec_uops [FETCH_WIDTH];
    uop_insn           hold_q   [HOLD_DEPTH];
    uop_insn           hold_d   [HOLD_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d;
    logic              accept_c;
    logic [FREE_W-1:0] free_c;
    int unsigned       n_act_c, n_push_c;

    for (genvar l = 0; l < FETCH_WIDTH; l++) begin : g_lane
        decode_lane #(.INSTRUCTION_WIDTH(INSTRUCTION_WIDTH)) u_lane (
            .insn_i  (io.fetch_ops_in[l]),
            .uop_o_c (dec_uops[l])
        );
    end

    assign free_c             = io.iq_free_slots_in;
    assign io.fetch_ready_out = ready_q;

    // IQ side: push min(count, PUSH_WIDTH, free) oldest-first; unused lanes driven to zero.
    always_comb begin
        n_push_c = 32'(count_q);
        if (n_push_c > PUSH_WIDTH) n_push_c = PUSH_WIDTH;
        if (n_push_c > 32'(free_c)) n_push_c = 32'(free_c);
        if (flush_in) n_push_c = 0;
        io.iq_push_count_out = PCNT_W'(n_push_c);
        for (int unsigned i = 0; i < PUSH_WIDTH; i++) begin
            io.iq_uops_out[i] = (i < n_push_c) ? hold_q[head_q + PTR_W'(i)] : '0;
        end
    end

    // Fetch side: active lanes packed contiguously at tail, holes skipped.
    always_comb begin
        hold_d   = hold_q;
        n_act_c  = 0;
        accept_c = io.fetch_valid_in & ready_q & ~flush_in;
        if (accept_c) begin
            for (int unsigned l = 0; l < FETCH_WIDTH; l++) begin
                if (io.fetch_lane_mask_in[l]) begin
                    hold_d[tail_q + PTR_W'(n_act_c)] = dec_uops[l];
                    n_act_c = n_act_c + 1;
                end
            end
        end
        tail_d  = tail_q + PTR_W'(n_act_c);
        head_d  = head_q + PTR_W'(n_push_c);
        count_d = CNT_W'(32'(count_q) + n_act_c - n_push_c);
        if (flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
        ready_d = (HOLD_DEPTH - 32'(count_d)) >= FETCH_WIDTH;
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            for (int i = 0; i < int'(HOLD_DEPTH); i++) hold_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

`ifdef DECODE_PERF_EN
    logic [31:0] perf_dec_q, perf_dec_d, perf_stall_q, perf_stall_d;
    logic [32:0] dec_sum_c;

    // Saturating counters, cleared by flush.
    always_comb begin
        dec_sum_c    = {1'b0, perf_dec_q} + 33'(n_act_c);
        perf_dec_d   = dec_sum_c[32] ? '1 : dec_sum_c[31:0];
        perf_stall_d = perf_stall_q;
        if (io.fetch_valid_in && !ready_q && !(&perf_stall_q)) perf_stall_d = perf_stall_q + 32'd1;
        if (flush_in) begin
            perf_dec_d   = '0;
            perf_stall_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            perf_dec_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_dec_q   <= perf_dec_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_decoded_out = perf_dec_q;
    assign perf_stall_out   = perf_stall_q;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cycle table, wrap sequence, randomized run against a queue model, mid-run reset.
module tb_decode_stage;
    import uop_pkg::*;

    localparam int unsigned FREE_W = $clog2(INSTR_Q_DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   n_checks = 0;
    int   n_pass   = 0;

`ifdef DECODE_PERF_EN
    logic [31:0] perf_dec, perf_stall;
`endif

    always #5 clk = ~clk;

    decode_stage_if #(.INSTRUCTION_WIDTH(32), .FETCH_WIDTH(2), .PUSH_WIDTH(INSTR_Q_WIDTH),
                      .IQ_DEPTH(INSTR_Q_DEPTH)) bus ();

    decode_stage #(.INSTRUCTION_WIDTH(32), .FETCH_WIDTH(2), .PUSH_WIDTH(INSTR_Q_WIDTH),
                   .HOLD_DEPTH(4), .IQ_DEPTH(INSTR_Q_DEPTH)) dut (
        .clk_in   (clk),
        .rst_N_in (rst_n),
        .flush_in (flush),
        .io       (bus)
`ifdef DECODE_PERF_EN
        ,
        .perf_decoded_out (perf_dec),
        .perf_stall_out   (perf_stall)
`endif
    );

    typedef struct {
        logic        v;
        logic [1:0]  m;
        logic [31:0] i0, i1;
        int          fr;
        logic        fl;
        logic        rdy;
        int          np;
        uop_insn     e0, e1;
    } vec_t;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    // Assembles an instruction of the given kind and returns the uop it must decode to.
    function automatic void enc_uop(input int kind, input logic [4:0] rd, rs1, rs2,
                                    input logic [31:0] imm, output logic [31:0] enc,
                                    output uop_insn u);
        logic [12:0] b;
        u = '0;
        b = {imm[12:1], 1'b0};
        case (kind)
            0: begin enc = {7'h00, rs2, rs1, 3'b000, rd, 7'h33}; u = '{UOP_ADD, rd, rs1, rs2, 32'h0}; end
            1: begin enc = {7'h20, rs2, rs1, 3'b000, rd, 7'h33}; u = '{UOP_SUB, rd, rs1, rs2, 32'h0}; end
            2: begin enc = {imm[11:0], rs1, 3'b000, rd, 7'h13};
                     u = '{UOP_ADDI, rd, rs1, 5'd0, {{20{imm[11]}}, imm[11:0]}}; end
            3: begin enc = {imm[11:0], rs1, 3'b010, rd, 7'h03};
                     u = '{UOP_LW, rd, rs1, 5'd0, {{20{imm[11]}}, imm[11:0]}}; end
            4: begin enc = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
                     u = '{UOP_SW, 5'd0, rs1, rs2, {{20{imm[11]}}, imm[11:0]}}; end
            5: begin enc = {b[12], b[10:5], rs2, rs1, 3'b000, b[4:1], b[11], 7'h63};
                     u = '{UOP_BEQ, 5'd0, rs1, rs2, {{19{b[12]}}, b}}; end
            6: begin enc = {imm[31:12], rd, 7'h37}; u = '{UOP_LUI, rd, 5'd0, 5'd0, {imm[31:12], 12'h0}}; end
            7: begin enc = {imm[31:7], 7'h7F}; u = '0; end
            default: begin enc = {7'h00, rs2, rs1, 3'b001, rd, 7'h33}; u = '0; end
        endcase
    endfunction

    function automatic vec_t row(input logic v, input logic [1:0] m, input logic [31:0] i0, i1,
                                 input int fr, input logic fl, input logic rdy, input int np,
                                 input uop_insn e0, e1);
        vec_t r;
        r.v = v; r.m = m; r.i0 = i0; r.i1 = i1; r.fr = fr; r.fl = fl;
        r.rdy = rdy; r.np = np; r.e0 = e0; r.e1 = e1;
        return r;
    endfunction

    task automatic apply(input logic v, input logic [1:0] m, input logic [31:0] i0, i1,
                         input int fr, input logic fl);
        @(negedge clk);
        bus.fetch_valid_in     = v;
        bus.fetch_lane_mask_in = m;
        bus.fetch_ops_in[0]    = i0;
        bus.fetch_ops_in[1]    = i1;
        bus.iq_free_slots_in   = FREE_W'(fr);
        flush                  = fl;
        #1;
    endtask

    task automatic check_out(input string tag, input logic er, input int ep, input uop_insn e0, e1);
        chk({tag, "_ready"}, 64'(bus.fetch_ready_out), 64'(er));
        chk({tag, "_push"},  64'(bus.iq_push_count_out), 64'(ep));
        chk({tag, "_uop0"},  64'(bus.iq_uops_out[0]), 64'(e0));
        chk({tag, "_uop1"},  64'(bus.iq_uops_out[1]), 64'(e1));
    endtask

    vec_t        tbl[$];
    uop_insn     q[$];
    uop_insn     nz;
    logic [31:0] eA, eB, eC, eD, eE, eF, eG;
    uop_insn     uA, uB, uC, uD, uE, uF, uG;
    logic [31:0] wenc[6];
    uop_insn     wu[6];

    initial begin
        nz = '0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.fetch_valid_in = 1'b0;
        bus.fetch_lane_mask_in = '0;
        bus.fetch_ops_in = '0;
        bus.iq_free_slots_in = '0;

        enc_uop(0, 5'd1, 5'd2, 5'd3, 32'd0, eA, uA);
        enc_uop(1, 5'd4, 5'd5, 5'd6, 32'd0, eB, uB);
        enc_uop(2, 5'd7, 5'd8, 5'd0, 32'hFFFF_FFFB, eC, uC);
        enc_uop(3, 5'd9, 5'd10, 5'd0, 32'd16, eD, uD);
        enc_uop(4, 5'd0, 5'd12, 5'd11, 32'hFFFF_FFF8, eE, uE);
        enc_uop(5, 5'd0, 5'd13, 5'd14, 32'd12, eF, uF);
        enc_uop(6, 5'd15, 5'd0, 5'd0, 32'hABCD_E000, eG, uG);

        // Reset state
        #2;
        check_out("reset", 1'b0, 0, nz, nz);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_out("post_rst_no_edge", 1'b0, 0, nz, nz);

        // Cycle-by-cycle directed table
        tbl.push_back(row(1, 2'b11, eA, eB, 8, 0, 1, 0, nz, nz));
        tbl.push_back(row(0, 2'b00, 0, 0, 8, 0, 1, 2, uA, uB));
        tbl.push_back(row(0, 2'b00, 0, 0, 8, 0, 1, 0, nz, nz));
        tbl.push_back(row(1, 2'b11, eA, eB, 0, 0, 1, 0, nz, nz));
        tbl.push_back(row(1, 2'b11, eC, eD, 0, 0, 1, 0, nz, nz));
        tbl.push_back(row(1, 2'b11, eE, eF, 0, 0, 0, 0, nz, nz));
        tbl.push_back(row(1, 2'b11, eE, eF, 8, 0, 0, 2, uA, uB));
        tbl.push_back(row(1, 2'b11, eE, eF, 8, 0, 1, 2, uC, uD));
        tbl.push_back(row(0, 2'b00, 0, 0, 8, 0, 1, 2, uE, uF));
        tbl.push_back(row(0, 2'b00, 0, 0, 8, 0, 1, 0, nz, nz));
        tbl.push_back(row(1, 2'b10, eA, eG, 8, 0, 1, 0, nz, nz));
        tbl.push_back(row(1, 2'b00, eC, eD, 8, 0, 1, 1, uG, nz));
        tbl.push_back(row(0, 2'b00, 0, 0, 8, 0, 1, 0, nz, nz));
        tbl.push_back(row(1, 2'b11, 32'h0, eA, 8, 0, 1, 0, nz, nz));
        tbl.push_back(row(0, 2'b00, 0, 0, 8, 0, 1, 2, nz, uA));
        tbl.push_back(row(1, 2'b11, eB, eC, 1, 0, 1, 0, nz, nz));
        tbl.push_back(row(0, 2'b00, 0, 0, 1, 0, 1, 1, uB, nz));
        tbl.push_back(row(0, 2'b00, 0, 0, 8, 0, 1, 1, uC, nz));
        tbl.push_back(row(1, 2'b11, eA, eB, 0, 0, 1, 0, nz, nz));
        tbl.push_back(row(1, 2'b01, eC, eD, 0, 0, 1, 0, nz, nz));
        tbl.push_back(row(1, 2'b11, eE, eF, 8, 1, 0, 0, nz, nz));
        tbl.push_back(row(0, 2'b00, 0, 0, 8, 0, 1, 0, nz, nz));
        tbl.push_back(row(1, 2'b11, eA, eB, 8, 1, 1, 0, nz, nz));
        tbl.push_back(row(0, 2'b00, 0, 0, 8, 0, 1, 0, nz, nz));
        tbl.push_back(row(1, 2'b01, eD, eE, 8, 0, 1, 0, nz, nz));
        tbl.push_back(row(0, 2'b00, 0, 0, 8, 0, 1, 1, uD, nz));
        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].m, tbl[i].i0, tbl[i].i1, tbl[i].fr, tbl[i].fl);
            check_out($sformatf("row%0d", i), tbl[i].rdy, tbl[i].np, tbl[i].e0, tbl[i].e1);
        end

        // Pointer wrap: six single-uop beats, each pushed the following cycle
        for (int k = 0; k < 6; k++) enc_uop(2, 5'(k + 1), 5'(k), 5'd0, 32'(k * 3), wenc[k], wu[k]);
        for (int k = 0; k < 7; k++) begin
            apply(k < 6, 2'b01, (k < 6) ? wenc[k % 6] : 32'h0, 32'h0, 8, 0);
            check_out($sformatf("wrap%0d", k), 1'b1, (k > 0) ? 1 : 0, (k > 0) ? wu[k - 1] : nz, nz);
        end

        // Randomized run against a FIFO model
        begin
            logic        rdy_m = 1'b1;
            logic        v, fl;
            logic [1:0]  m;
            logic [31:0] i0, i1;
            uop_insn     u0, u1;
            int          fr, ep;
`ifdef DECODE_PERF_EN
            longint      pd = 0, ps = 0;
`endif
            q.delete();
            for (int c = 0; c < 400; c++) begin
                v  = ($urandom % 4) != 0;
                m  = 2'($urandom);
                fr = $urandom_range(0, 8);
                fl = (c == 0) || ($urandom % 16 == 0);
                enc_uop($urandom_range(0, 8), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, i0, u0);
                enc_uop($urandom_range(0, 8), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, i1, u1);
                apply(v, m, i0, i1, fr, fl);
                ep = q.size();
                if (ep > 2) ep = 2;
                if (ep > fr) ep = fr;
                if (fl) ep = 0;
                check_out($sformatf("rnd%0d", c), rdy_m, ep, (ep > 0) ? q[0] : nz, (ep > 1) ? q[1] : nz);
`ifdef DECODE_PERF_EN
                if (c > 0) begin
                    chk("rnd_perf_dec", 64'(perf_dec), 64'(pd));
                    chk("rnd_perf_stall", 64'(perf_stall), 64'(ps));
                end
`endif
                @(posedge clk);
                if (fl) begin
                    q.delete();
`ifdef DECODE_PERF_EN
                    pd = 0; ps = 0;
`endif
                end else begin
                    repeat (ep) void'(q.pop_front());
                    if (v && rdy_m) begin
                        if (m[0]) q.push_back(u0);
                        if (m[1]) q.push_back(u1);
`ifdef DECODE_PERF_EN
                        pd = pd + longint'(m[0]) + longint'(m[1]);
`endif
                    end
`ifdef DECODE_PERF_EN
                    if (v && !rdy_m) ps = ps + 1;
`endif
                end
                rdy_m = (4 - q.size()) >= 2;
            end
        end

        // Reset asserted with uops held: outputs drop at once, nothing survives
        apply(0, 2'b00, 0, 0, 0, 1);
        apply(1, 2'b11, eA, eB, 0, 0);
        @(negedge clk);
        bus.fetch_valid_in = 1'b0;
        bus.iq_free_slots_in = FREE_W'(8);
        #1;
        check_out("held_before_rst", 1'b1, 2, uA, uB);
        rst_n = 1'b0;
        #1;
        check_out("mid_rst", 1'b0, 0, nz, nz);
`ifdef DECODE_PERF_EN
        chk("mid_rst_perf_dec", 64'(perf_dec), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 2'b00, 0, 0, 8, 0);
        check_out("after_rst", 1'b1, 0, nz, nz);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
